// File: rtl/muon_capture_buffer.sv
// muon_capture_buffer: captures a PRE+POST sample window plus timestamp per accepted trigger
// into round-robin buffers that the processor reads out and then releases.
module muon_capture_buffer #(
  parameter int ADC_WIDTH    = 12,
  parameter int PRE          = 8,
  parameter int POST         = 16,
  parameter int TRIG_LATENCY = 8,
  parameter int NBUF         = 4,
  parameter int TS_WIDTH     = 32
) (
  input  logic                            CLK120,
  input  logic                            RESET,
  input  logic [ADC_WIDTH-1:0]            ADC0,
  input  logic [ADC_WIDTH-1:0]            ADC1,
  input  logic [ADC_WIDTH-1:0]            ADC2,
  input  logic [ADC_WIDTH-1:0]            ADC_SSD,
  input  logic                            TRIG,
  input  logic                            ENABLE,
  input  logic [$clog2(NBUF)-1:0]         RD_BUF,
  input  logic [$clog2(PRE+POST)-1:0]     RD_SAMPLE,
  output logic [4*ADC_WIDTH-1:0]          RD_DATA,
  output logic [TS_WIDTH-1:0]             RD_TS,
  input  logic                            RD_DONE,
  input  logic [$clog2(NBUF)-1:0]         RD_DONE_BUF,
  output logic [NBUF-1:0]                 BUF_FULL,
  output logic                            DONE,
  output logic                            BUSY,
  output logic [15:0]                     LOST_CNT
);
  localparam int WIN = PRE + POST;
  localparam int DLY = PRE + TRIG_LATENCY;
  localparam int DW  = 4 * ADC_WIDTH;
  localparam int BW  = $clog2(NBUF);
  localparam int CW  = $clog2(WIN);
  localparam int AW  = $clog2(NBUF * WIN);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CAPTURE = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       wr_buf_q, wr_buf_d;
  logic [NBUF-1:0]     full_q, full_d;
  logic                done_q, done_d;
  logic [15:0]         lost_q, lost_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic [TS_WIDTH-1:0] rd_ts_q, rd_ts_d;
  logic [DW-1:0]       dly_q [DLY];
  logic [DW-1:0]       dly_d [DLY];
  logic [DW-1:0]       mem [NBUF*WIN];
  logic [TS_WIDTH-1:0] ts_mem [NBUF];
  logic                accept, lose, last, we;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic [NBUF-1:0]     clr;

  always_comb begin
    accept    = state_q == IDLE && TRIG && ENABLE && !full_q[wr_buf_q];
    lose      = TRIG && ENABLE && !accept;
    last      = state_q == CAPTURE && cnt_q == CW'(WIN - 1);
    we        = (accept || state_q == CAPTURE) && !RESET;
    wr_addr   = AW'(wr_buf_q) * AW'(WIN) + AW'(state_q == IDLE ? '0 : cnt_q);
    rd_addr   = AW'(RD_BUF) * AW'(WIN) + AW'(RD_SAMPLE);
    state_d   = accept ? CAPTURE : last ? IDLE : state_q;
    cnt_d     = accept ? CW'(1) : state_q == CAPTURE ? cnt_q + CW'(1) : cnt_q;
    wr_buf_d  = last ? wr_buf_q + BW'(1) : wr_buf_q;
    clr       = RD_DONE ? NBUF'(1) << RD_DONE_BUF : '0;
    // A completing window's set wins; its buffer cannot be full, so a clear there is moot.
    full_d    = (full_q & ~clr) | (last ? NBUF'(1) << wr_buf_q : '0);
    done_d    = last;
    lost_d    = lose && lost_q != 16'hFFFF ? lost_q + 16'd1 : lost_q;
    ts_d      = ts_q + TS_WIDTH'(1);
    rd_data_d = mem[rd_addr];
    rd_ts_d   = ts_mem[RD_BUF];
    dly_d[0]  = {ADC_SSD, ADC2, ADC1, ADC0};
    for (int i = 1; i < DLY; i++) dly_d[i] = dly_q[i-1];
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_buf_q  <= '0;
      full_q    <= '0;
      done_q    <= 1'b0;
      lost_q    <= '0;
      ts_q      <= '0;
      rd_data_q <= '0;
      rd_ts_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_buf_q  <= wr_buf_d;
      full_q    <= full_d;
      done_q    <= done_d;
      lost_q    <= lost_d;
      ts_q      <= ts_d;
      rd_data_q <= rd_data_d;
      rd_ts_q   <= rd_ts_d;
    end
  end

  always_ff @(posedge CLK120) begin
    dly_q <= dly_d;
    if (we) mem[wr_addr] <= dly_q[DLY-1];
    if (accept && !RESET) ts_mem[wr_buf_q] <= ts_q;
  end

  assign RD_DATA  = rd_data_q;
  assign RD_TS    = rd_ts_q;
  assign BUF_FULL = full_q;
  assign DONE     = done_q;
  assign BUSY     = state_q == CAPTURE;
  assign LOST_CNT = lost_q;
endmodule

// File: tb/tb_muon_capture_buffer.sv
// tb_muon_capture_buffer: directed scenarios for capture windows, allocation, loss counting and reset.
module tb_muon_capture_buffer;
  logic        clk = 0, rst = 1, trig = 0, en = 1, rd_done = 0;
  logic [11:0] adc0, adc1, adc2, ssd;
  logic [1:0]  rd_buf = 0, rd_done_buf = 0;
  logic [4:0]  rd_sample = 0;
  logic [47:0] rd_data;
  logic [31:0] rd_ts;
  logic [3:0]  buf_full;
  logic        done, busy;
  logic [15:0] lost_cnt;
  int cyc = 0, checks = 0, errors = 0;

  muon_capture_buffer dut (
    .CLK120(clk), .RESET(rst), .ADC0(adc0), .ADC1(adc1), .ADC2(adc2), .ADC_SSD(ssd),
    .TRIG(trig), .ENABLE(en), .RD_BUF(rd_buf), .RD_SAMPLE(rd_sample), .RD_DATA(rd_data),
    .RD_TS(rd_ts), .RD_DONE(rd_done), .RD_DONE_BUF(rd_done_buf), .BUF_FULL(buf_full),
    .DONE(done), .BUSY(busy), .LOST_CNT(lost_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] expd(input int c);
    return {12'(~c), 12'(c * 3), 12'(c + 1000), 12'(c)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    {ssd, adc2, adc1, adc0} = expd(cyc);
    trig = 0;
    rd_done = 0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst = 1; trig = 0; rd_done = 0; en = 1;
    tick(); tick();
    rst = 0;
    cyc = 0;
    {ssd, adc2, adc1, adc0} = expd(cyc);
  endtask

  task automatic trig_at(input int c);
    goto(c);
    trig = 1;
    tick();
  endtask

  task automatic rd(input logic [1:0] b, input logic [4:0] s);
    rd_buf = b; rd_sample = s;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (buf_full !== 4'b0000) begin errors++; $display("FAIL reset_full got %b exp 0000", buf_full); end
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL reset_done_busy got %b exp 00", {done, busy}); end
    checks++; if (lost_cnt !== 16'd0) begin errors++; $display("FAIL reset_lost got %0d exp 0", lost_cnt); end
    checks++; if (rd_data !== 48'd0 || rd_ts !== 32'd0) begin errors++; $display("FAIL reset_rd got %h/%h exp 0/0", rd_data, rd_ts); end
  endtask

  task automatic test_window();
    trig_at(100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL win_busy101 got %b exp 1", busy); end
    goto(123);
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL win_123 got %b exp 01", {done, busy}); end
    goto(124);
    checks++; if ({done, busy, buf_full} !== 6'b10_0001) begin errors++; $display("FAIL win_124 got %b exp 100001", {done, busy, buf_full}); end
    goto(125);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL win_done125 got %b exp 0", done); end
    rd(0, 0);
    checks++; if (rd_data !== expd(84)) begin errors++; $display("FAIL win_s0 got %h exp %h", rd_data, expd(84)); end
    checks++; if (rd_ts !== 32'd100) begin errors++; $display("FAIL win_ts got %0d exp 100", rd_ts); end
    rd(0, 8);
    checks++; if (rd_data !== expd(92)) begin errors++; $display("FAIL win_s8 got %h exp %h", rd_data, expd(92)); end
    rd(0, 23);
    checks++; if (rd_data !== expd(107)) begin errors++; $display("FAIL win_s23 got %h exp %h", rd_data, expd(107)); end
  endtask

  task automatic test_ring_full();
    do_reset();
    for (int i = 0; i < 5; i++) trig_at(20 + 40 * i);
    goto(200);
    checks++; if (buf_full !== 4'b1111 || lost_cnt !== 16'd1) begin errors++; $display("FAIL ring_full got %b/%0d exp 1111/1", buf_full, lost_cnt); end
    rd_done_buf = 0; rd_done = 1;
    tick();
    checks++; if (buf_full !== 4'b1110) begin errors++; $display("FAIL ring_release got %b exp 1110", buf_full); end
    trig_at(202);
    goto(226);
    checks++; if (buf_full !== 4'b1111 || lost_cnt !== 16'd1) begin errors++; $display("FAIL ring_refill got %b/%0d exp 1111/1", buf_full, lost_cnt); end
    rd(0, 8);
    checks++; if (rd_data !== expd(194) || rd_ts !== 32'd202) begin errors++; $display("FAIL ring_buf0 got %h/%0d exp %h/202", rd_data, rd_ts, expd(194)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    trig_at(100);
    trig_at(105);
    checks++; if (lost_cnt !== 16'd1) begin errors++; $display("FAIL b2b_lost got %0d exp 1", lost_cnt); end
    goto(124);
    checks++; if ({done, buf_full} !== 5'b1_0001) begin errors++; $display("FAIL b2b_124 got %b exp 10001", {done, buf_full}); end
    trig_at(124);
    checks++; if (busy !== 1'b1 || lost_cnt !== 16'd1) begin errors++; $display("FAIL b2b_accept got %b/%0d exp 1/1", busy, lost_cnt); end
    goto(148);
    checks++; if (buf_full !== 4'b0011) begin errors++; $display("FAIL b2b_full got %b exp 0011", buf_full); end
    rd(1, 8);
    checks++; if (rd_data !== expd(124 - 8) || rd_ts !== 32'd124) begin errors++; $display("FAIL b2b_buf1 got %h/%0d exp %h/124", rd_data, rd_ts, expd(116)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    trig_at(100);
    trig_at(105);
    goto(110);
    do_reset();
    checks++; if (buf_full !== 4'b0000 || lost_cnt !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid got %b/%0d/%b exp 0000/0/0", buf_full, lost_cnt, busy); end
    trig_at(30);
    goto(54);
    checks++; if (buf_full !== 4'b0001) begin errors++; $display("FAIL rstmid_full got %b exp 0001", buf_full); end
    rd(0, 8);
    checks++; if (rd_data !== expd(22)) begin errors++; $display("FAIL rstmid_data got %h exp %h", rd_data, expd(22)); end
  endtask

  task automatic test_release_race();
    do_reset();
    for (int i = 0; i < 4; i++) trig_at(20 + 40 * i);
    goto(170);
    rd_done_buf = 0; rd_done = 1;
    trig_at(170);
    checks++; if (lost_cnt !== 16'd1 || buf_full !== 4'b1110 || busy !== 1'b0) begin errors++; $display("FAIL race_lost got %0d/%b/%b exp 1/1110/0", lost_cnt, buf_full, busy); end
    trig_at(171);
    checks++; if (busy !== 1'b1 || lost_cnt !== 16'd1) begin errors++; $display("FAIL race_accept got %b/%0d exp 1/1", busy, lost_cnt); end
    goto(195);
    checks++; if (buf_full !== 4'b1111) begin errors++; $display("FAIL race_full got %b exp 1111", buf_full); end
  endtask

  task automatic test_enable_saturate();
    do_reset();
    en = 0;
    trig_at(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en0_busy got %b exp 0", busy); end
    goto(50);
    checks++; if (buf_full !== 4'b0000 || lost_cnt !== 16'd0) begin errors++; $display("FAIL en0 got %b/%0d exp 0000/0", buf_full, lost_cnt); end
    en = 1;
    trig_at(60);
    goto(65);
    en = 0;
    goto(84);
    checks++; if ({done, buf_full} !== 5'b1_0001) begin errors++; $display("FAIL en_mid got %b exp 10001", {done, buf_full}); end
    en = 1;
    for (int i = 0; i < 3; i++) trig_at(100 + 40 * i);
    goto(210);
    for (int i = 0; i < 65534; i++) begin trig = 1; tick(); end
    checks++; if (lost_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got %h exp fffe", lost_cnt); end
    for (int i = 0; i < 5; i++) begin trig = 1; tick(); end
    checks++; if (lost_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got %h exp ffff", lost_cnt); end
  endtask

  initial begin
    {ssd, adc2, adc1, adc0} = expd(0);
    test_reset();
    test_window();
    test_ring_full();
    test_back_to_back();
    test_reset_mid();
    test_release_race();
    test_enable_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
